inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction sequencer placed directly upstream of the instruction memory in the polar decoder control path.
- On a start pulse it drives the memory address and enable, registers each 12-bit instruction, and presents it to the decoder datapath over a valid/ready handshake.
- It stops at an END opcode or at the last memory address, then pulses done.

Parameters:
- INST_W, 12: instruction width.
- ADDR_W, 8: instruction address width.
- INST_DEPTH, `CNT_INST_MAX: number of valid instruction words; the last valid address is INST_DEPTH-1.
- END_OP, 4'hF: opcode in inst[11:8] that terminates the program.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start_i, input, 1: single-cycle run request. Ignored unless the FSM is in IDLE.
- mem_en_o, output, 1: instruction memory enable.
- mem_addr_o, output, ADDR_W: instruction memory address. Equals pc.
- mem_inst_i, input, INST_W: instruction memory read data. Combinational, valid in the same cycle as mem_en_o/mem_addr_o.
- inst_valid_o, output, 1: inst_o holds an instruction for the datapath.
- inst_o, output, INST_W: registered instruction.
- inst_ready_i, input, 1: datapath accepts inst_o.
- busy_o, output, 1: high in every state except IDLE.
- done_o, output, 1: one-cycle pulse at program end.
- err_o, output, 1: sticky. Set when the program ran off INST_DEPTH without an END. Cleared by rst or by an accepted start_i.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-high (rst).
- Reset values: all outputs 0; pc=0; inst_q=0; FSM=IDLE. Reset mid-program aborts immediately; no done_o is generated.
- FSM states: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - mem_en_o=0, mem_addr_o=pc.
  - start_i → pc=0, clear err_o, go to FETCH.
- FETCH:
  - mem_en_o=1, mem_addr_o=pc.
  - If mem_inst_i[11:8]==END_OP → go to DONE. The END instruction is never issued.
  - Otherwise → inst_q<=mem_inst_i, go to ISSUE.
  - In both cases pc<=pc+1. If pc==INST_DEPTH-1, pc holds and the last_fetched flag is set.
- ISSUE:
  - inst_valid_o=1, inst_o=inst_q.
  - inst_o is stable while inst_valid_o=1 and inst_ready_i=0.
  - On inst_valid_o && inst_ready_i:
    - if last_fetched → set err_o, go to DONE;
    - else → go to FETCH.
- DONE:
  - done_o=1 for exactly one cycle, then go to IDLE.
- Latency and throughput, base build:
  - start_i at cycle T → first inst_valid_o at T+2.
  - Sustained throughput is 1 instruction per 2 cycles.
- pc arithmetic:
  - ADDR_W bits, increments only on a fetch.
  - pc never wraps; an address ≥INST_DEPTH is never driven.
- Boundary rules:
  - start_i outside IDLE (including in DONE) is ignored.
  - An END at address 0 → done_o at T+2 with no instruction issued.
  - An END at address INST_DEPTH-1 is a normal END; err_o stays 0.

Optional Feature:
- Macro: INST_FETCH_PREFETCH_EN.
- When defined, ISSUE fetches the next word in the same cycle as a handshake:
  - mem_en_o=1 in that cycle; the next word loads into inst_q directly and the FSM stays in ISSUE.
  - Throughput becomes 1 instruction per cycle.
  - If the fetched word is END, or last_fetched was already set, go to DONE with the same err_o rules as the base build.
  - mem_en_o=0 in ISSUE cycles without a handshake.
- When not defined, behaviour is the base FSM above.

Decomposition:
- Shared package/defines.v holds:
  - `CNT_INST_MAX;
  - opcode field positions [11:8] and operand field [7:0];
  - END_OP;
  - FSM state encodings: IDLE=2'd0, FETCH=2'd1, ISSUE=2'd2, DONE=2'd3.
- No sub-module. The PC counter and the FSM are a single always block pair.

Test Plan:
- Program {12'h101, 12'h202, 12'hF00}, inst_ready_i=1, base build: inst_o=12'h101 at T+2 and 12'h202 at T+4; done_o at T+6; err_o=0.
- Same program with INST_FETCH_PREFETCH_EN: instructions valid on consecutive cycles T+2 and T+3; done_o at T+4.
- inst_ready_i held 0 for 5 cycles while 12'h101 is valid: inst_o stays stable, mem_en_o=0, pc=1.
- Memory filled with no END: exactly INST_DEPTH instructions issued, then err_o=1 and a done_o pulse. A subsequent start_i clears err_o.
- rst asserted while in ISSUE: next cycle all outputs are 0 and FSM=IDLE; no done_o pulse.
- start_i pulsed while busy_o=1: pc unaffected, no restart; the END word at address 0 produces done_o at T+2.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction sequencer: depth, opcode field, END opcode, FSM encoding.
// CNT_INST_MAX may be overridden on the command line; it sets the number of valid instruction words.
`ifndef CNT_INST_MAX
`define CNT_INST_MAX 16
`endif

package inst_fetch_pkg;

  localparam int         INST_W_DEF     = 12;
  localparam int         ADDR_W_DEF     = 8;
  localparam int         INST_DEPTH_DEF = `CNT_INST_MAX;
  localparam logic [3:0] END_OP_DEF     = 4'hF;

  // Opcode sits in the top nibble, operand in the low byte.
  localparam int OP_MSB   = 11;
  localparam int OP_LSB   = 8;
  localparam int OPND_MSB = 7;
  localparam int OPND_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction sequencer feeding the polar decoder datapath over a valid/ready handshake.
// Optional back-to-back issue during a handshake is enabled with INST_FETCH_PREFETCH_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int         INST_W     = INST_W_DEF,
  parameter int         ADDR_W     = ADDR_W_DEF,
  parameter int         INST_DEPTH = INST_DEPTH_DEF,
  parameter logic [3:0] END_OP     = END_OP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [INST_W-1:0] mem_inst_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  input  logic              inst_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INST_DEPTH - 1);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] inst_q;
  logic              err_q;
  logic              last_fetched;
  logic              fetch;
  logic              handshake;
  logic              opcode_end;
  logic              err_set;
  logic              start_acc;

  assign opcode_end = (mem_inst_i[OP_MSB:OP_LSB] == END_OP);
  assign handshake  = (state_q == ISSUE) && inst_ready_i;
  assign err_set    = handshake && last_fetched;
  assign start_acc  = (state_q == IDLE) && start_i;

  // pc saturates at the last valid address; last_fetched records that it was read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc           <= '0;
      inst_q       <= '0;
      err_q        <= 1'b0;
      last_fetched <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        pc           <= '0;
        err_q        <= 1'b0;
        last_fetched <= 1'b0;
      end
      if (fetch) begin
        if (!opcode_end) inst_q <= mem_inst_i;
        if (pc == LAST_ADDR) last_fetched <= 1'b1;
        else                 pc           <= pc + 1'b1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) state_d = FETCH;
      FETCH: begin
        fetch   = 1'b1;
        state_d = opcode_end ? DONE : ISSUE;
      end
      ISSUE: begin
        if (handshake) begin
          if (last_fetched) begin
            state_d = DONE;
          end else begin
`ifdef INST_FETCH_PREFETCH_EN
            fetch   = 1'b1;
            state_d = opcode_end ? DONE : ISSUE;
`else
            state_d = FETCH;
`endif
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en_o     = fetch;
    mem_addr_o   = pc;
    inst_valid_o = (state_q == ISSUE);
    inst_o       = inst_q;
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == DONE);
    err_o        = err_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a combinational instruction memory model.
// Expected timing follows the build: INST_FETCH_PREFETCH_EN selects the one-per-cycle variant.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int DEPTH = INST_DEPTH_DEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        inst_ready_i = 1'b0;
  logic        mem_en_o;
  logic [7:0]  mem_addr_o;
  logic [11:0] mem_inst_i;
  logic        inst_valid_o;
  logic [11:0] inst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  logic [11:0] mem [0:255];
  int check_count = 0;
  int error_count = 0;

  assign mem_inst_i = mem[mem_addr_o];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mem_en_o     (mem_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_inst_i   (mem_inst_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_ready_i (inst_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start/ready for one edge, then drops start so it behaves as a pulse.
  task automatic applyStimulus(input logic start_v, input logic ready_v);
    start_i      = start_v;
    inst_ready_i = ready_v;
    step();
    start_i = 1'b0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " mem_en"}, 32'(mem_en_o), 32'd0);
    checkOutput({tag, " addr"},   32'(mem_addr_o), 32'd0);
    checkOutput({tag, " valid"},  32'(inst_valid_o), 32'd0);
    checkOutput({tag, " inst"},   32'(inst_o), 32'd0);
    checkOutput({tag, " busy"},   32'(busy_o), 32'd0);
    checkOutput({tag, " done"},   32'(done_o), 32'd0);
    checkOutput({tag, " err"},    32'(err_o), 32'd0);
  endtask

  // Follows a running program until done_o, checking every issued word against memory order.
  task automatic runProgram(input string tag, input int exp_count, input logic exp_err);
    int issued   = 0;
    int max_addr = 0;
    bit seen     = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      if (mem_en_o && int'(mem_addr_o) > max_addr) max_addr = int'(mem_addr_o);
      if (inst_valid_o && inst_ready_i) begin
        if (issued < 256) checkOutput({tag, " issued word"}, 32'(inst_o), 32'(mem[issued]));
        issued++;
      end
      if (done_o) seen = 1'b1;
      else step();
    end
    checkOutput({tag, " done reached"}, 32'(seen), 32'd1);
    checkOutput({tag, " issue count"}, 32'(issued), 32'(exp_count));
    checkOutput({tag, " err"}, 32'(err_o), 32'(exp_err));
    checkOutput({tag, " addr in range"}, 32'(max_addr < DEPTH), 32'd1);
    step();
    checkOutput({tag, " done one cycle"}, 32'(done_o), 32'd0);
    checkOutput({tag, " idle after"}, 32'(busy_o), 32'd0);
  endtask

  task automatic loadProgramA();
    clearMem();
    mem[0] = 12'h101;
    mem[1] = 12'h202;
    mem[2] = 12'hF00;
  endtask

  initial begin
    clearMem();
    step();
    step();
    checkIdleOutputs("reset");
    rst = 1'b0;
    step();

    // Program A with the datapath always ready
    loadProgramA();
    applyStimulus(1'b1, 1'b1);
    checkOutput("A T+1 mem_en", 32'(mem_en_o), 32'd1);
    checkOutput("A T+1 addr", 32'(mem_addr_o), 32'd0);
    checkOutput("A T+1 busy", 32'(busy_o), 32'd1);
    checkOutput("A T+1 valid", 32'(inst_valid_o), 32'd0);
    step();
    checkOutput("A T+2 valid", 32'(inst_valid_o), 32'd1);
    checkOutput("A T+2 inst", 32'(inst_o), 32'h101);
`ifdef INST_FETCH_PREFETCH_EN
    checkOutput("A T+2 mem_en", 32'(mem_en_o), 32'd1);
    checkOutput("A T+2 addr", 32'(mem_addr_o), 32'd1);
    step();
    checkOutput("A T+3 valid", 32'(inst_valid_o), 32'd1);
    checkOutput("A T+3 inst", 32'(inst_o), 32'h202);
    step();
    checkOutput("A T+4 done", 32'(done_o), 32'd1);
    checkOutput("A T+4 err", 32'(err_o), 32'd0);
`else
    checkOutput("A T+2 mem_en", 32'(mem_en_o), 32'd0);
    step();
    checkOutput("A T+3 valid", 32'(inst_valid_o), 32'd0);
    checkOutput("A T+3 addr", 32'(mem_addr_o), 32'd1);
    step();
    checkOutput("A T+4 valid", 32'(inst_valid_o), 32'd1);
    checkOutput("A T+4 inst", 32'(inst_o), 32'h202);
    step();
    checkOutput("A T+5 done", 32'(done_o), 32'd0);
    step();
    checkOutput("A T+6 done", 32'(done_o), 32'd1);
    checkOutput("A T+6 err", 32'(err_o), 32'd0);
`endif
    step();
    checkOutput("A after done", 32'(done_o), 32'd0);
    checkOutput("A idle", 32'(busy_o), 32'd0);

    // Datapath stalls for five cycles on the first word
    loadProgramA();
    applyStimulus(1'b1, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall valid", 32'(inst_valid_o), 32'd1);
      checkOutput("stall inst", 32'(inst_o), 32'h101);
      checkOutput("stall mem_en", 32'(mem_en_o), 32'd0);
      checkOutput("stall pc", 32'(mem_addr_o), 32'd1);
      step();
    end
    inst_ready_i = 1'b1;
    #1;
    runProgram("stall drain", 2, 1'b0);

    // Reset while a word is waiting in ISSUE
    loadProgramA();
    applyStimulus(1'b1, 1'b0);
    step();
    checkOutput("pre-reset valid", 32'(inst_valid_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkIdleOutputs("mid reset");
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("post reset done", 32'(done_o), 32'd0);
      checkOutput("post reset busy", 32'(busy_o), 32'd0);
    end

    // No END anywhere: every word issued, then the error flag
    clearMem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 12'h010 + 12'(i);
    applyStimulus(1'b1, 1'b1);
    runProgram("no end", DEPTH, 1'b1);
    checkOutput("err sticky", 32'(err_o), 32'd1);

    // END at address 0, with start held through FETCH and DONE
    mem[0] = 12'hF00;
    applyStimulus(1'b1, 1'b1);
    checkOutput("restart err cleared", 32'(err_o), 32'd0);
    checkOutput("restart addr", 32'(mem_addr_o), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("end0 done T+2", 32'(done_o), 32'd1);
    checkOutput("end0 no issue", 32'(inst_valid_o), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("start in DONE ignored", 32'(busy_o), 32'd0);
    checkOutput("end0 done once", 32'(done_o), 32'd0);

    // END at the last valid address is a normal finish
    clearMem();
    for (int i = 0; i < DEPTH - 1; i++) mem[i] = 12'h0A0 + 12'(i);
    mem[DEPTH-1] = 12'hF00;
    applyStimulus(1'b1, 1'b1);
    runProgram("end last", DEPTH - 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
